// File: rtl/reg_cmd_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_cmd_assembler_if
// Brief    : Byte-stream input and register-command output bundle for
//            reg_cmd_assembler. The master drives the SPI byte side, the
//            slave (the assembler) drives the command and status side.
// Revision : 1.0  initial release
// ============================================================================
interface reg_cmd_assembler_if;
  logic        spi_cs_n;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [7:0]  reg_addr;
  logic [16:0] reg_data;
  logic        reg_input_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output spi_cs_n, rx_byte, rx_byte_valid,
    input  reg_addr, reg_data, reg_input_valid, frame_err, err_code, busy
  );

  modport slave (
    input  spi_cs_n, rx_byte, rx_byte_valid,
    output reg_addr, reg_data, reg_input_valid, frame_err, err_code, busy
  );
endinterface
`default_nettype wire

// File: rtl/reg_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module   : reg_cmd_assembler
// Brief    : Frames SPI receiver bytes into register commands (addr, 17-bit
//            data) with frame-length, inter-byte gap and optional checksum
//            validation. One single-cycle command pulse per good frame.
// Build    : define REG_CMD_CHECKSUM_EN for 5-byte frames whose last byte is
//            the XOR of bytes 0..3; undefined gives 4-byte frames.
// Revision : 1.0  initial release
// ============================================================================
module reg_cmd_assembler #(
  parameter int TIMEOUT_CYCLES = 4095
) (
  input wire                 sysClk,
  input wire                 sysRstN,
  reg_cmd_assembler_if.slave bus
);

`ifdef REG_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_ADDR  = 3'd0,
    S_DLO   = 3'd1,
    S_DHI   = 3'd2,
    S_FLG   = 3'd3,
    S_CHK   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_ADDR  = 3'd0,
    S_DLO   = 3'd1,
    S_DHI   = 3'd2,
    S_FLG   = 3'd3,
    S_DRAIN = 3'd5
  } state_t;
`endif

  localparam logic [11:0] TIMEOUT_VAL = 12'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [11:0] gap_q;
  logic [7:0]  addr_sh_q;
  logic [7:0]  data_lo_q;
  logic [7:0]  data_hi_q;
`ifdef REG_CMD_CHECKSUM_EN
  logic [7:0]  flags_q;
`endif
  logic [7:0]  reg_addr_q;
  logic [16:0] reg_data_q;
  logic        reg_valid_q;
  logic        frame_err_q;
  logic [1:0]  err_code_q;

  logic        accept;
  logic [11:0] gap_inc;

  assign accept  = bus.rx_byte_valid & ~bus.spi_cs_n;
  // Saturating next gap count; the frame is abandoned when this hits the limit.
  assign gap_inc = (gap_q == TIMEOUT_VAL) ? gap_q : gap_q + 12'd1;

  // Frame sequencer: byte capture, validation and registered command/status outputs.
  always_ff @(posedge sysClk or negedge sysRstN) begin
    if (!sysRstN) begin
      state_q     <= S_ADDR;
      gap_q       <= '0;
      addr_sh_q   <= '0;
      data_lo_q   <= '0;
      data_hi_q   <= '0;
`ifdef REG_CMD_CHECKSUM_EN
      flags_q     <= '0;
`endif
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      reg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      reg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_ADDR: begin
          if (accept) begin
            addr_sh_q <= bus.rx_byte;
            gap_q     <= '0;
            state_q   <= S_DLO;
          end
        end
        S_DRAIN: begin
          if (bus.spi_cs_n) state_q <= S_ADDR;
        end
        // Mid-frame states. Chip-select release takes priority over a
        // coinciding timeout: the frame is reported short.
        default: begin
          if (bus.spi_cs_n) begin
            frame_err_q <= 1'b1;
            err_code_q  <= 2'b01;
            gap_q       <= '0;
            state_q     <= S_ADDR;
          end else if (bus.rx_byte_valid) begin
            // An accepted byte always beats a timeout in the same cycle.
            gap_q <= '0;
            case (state_q)
              S_DLO: begin
                data_lo_q <= bus.rx_byte;
                state_q   <= S_DHI;
              end
              S_DHI: begin
                data_hi_q <= bus.rx_byte;
                state_q   <= S_FLG;
              end
`ifdef REG_CMD_CHECKSUM_EN
              S_FLG: begin
                flags_q <= bus.rx_byte;
                state_q <= S_CHK;
              end
              S_CHK: begin
                state_q <= S_DRAIN;
                if ((addr_sh_q ^ data_lo_q ^ data_hi_q ^ flags_q) == bus.rx_byte) begin
                  reg_addr_q  <= addr_sh_q;
                  reg_data_q  <= {flags_q[0], data_hi_q, data_lo_q};
                  reg_valid_q <= 1'b1;
                end else begin
                  frame_err_q <= 1'b1;
                  err_code_q  <= 2'b11;
                end
              end
`else
              S_FLG: begin
                reg_addr_q  <= addr_sh_q;
                reg_data_q  <= {bus.rx_byte[0], data_hi_q, data_lo_q};
                reg_valid_q <= 1'b1;
                state_q     <= S_DRAIN;
              end
`endif
              default: state_q <= S_ADDR;
            endcase
          end else begin
            gap_q <= gap_inc;
            if (gap_inc == TIMEOUT_VAL) begin
              frame_err_q <= 1'b1;
              err_code_q  <= 2'b10;
              state_q     <= S_DRAIN;
            end
          end
        end
      endcase
    end
  end

  assign bus.reg_addr        = reg_addr_q;
  assign bus.reg_data        = reg_data_q;
  assign bus.reg_input_valid = reg_valid_q;
  assign bus.frame_err       = frame_err_q;
  assign bus.err_code        = err_code_q;
  assign bus.busy            = (state_q != S_ADDR);

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_cmd_assembler
// Brief    : Self-checking bench for reg_cmd_assembler: directed frames from
//            the test plan followed by randomized byte traffic, all compared
//            cycle by cycle against a queue-based frame model.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_cmd_assembler;

  localparam int TO = 16;
`ifdef REG_CMD_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  reg_cmd_assembler_if bus ();

  reg_cmd_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .sysClk  (clk),
    .sysRstN (rstn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: bytes of the frame in progress, drain flag, idle count.
  logic [7:0]  m_q[$];
  bit          m_drain;
  int          m_idle;
  logic [7:0]  e_addr;
  logic [16:0] e_data;
  logic        e_valid, e_ferr, e_busy;
  logic [1:0]  e_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drain = 0;
    m_idle  = 0;
    e_addr  = '0; e_data = '0; e_valid = 0; e_ferr = 0; e_code = 2'b00; e_busy = 0;
  endtask

  // One clock of frame semantics expressed on the byte list itself.
  task automatic model(input logic cs, input logic v, input logic [7:0] b);
    logic [7:0] xs;
    logic [7:0] f1, f2, f3;
    e_valid = 0;
    e_ferr  = 0;
    if (m_drain) begin
      if (cs) m_drain = 0;
    end else if (m_q.size() == 0) begin
      if (v && !cs) begin
        m_q.push_back(b);
        m_idle = 0;
      end
    end else if (cs) begin
      e_ferr = 1; e_code = 2'b01;
      m_q.delete();
    end else if (v) begin
      m_q.push_back(b);
      m_idle = 0;
      if (m_q.size() == FLEN) begin
        xs = m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3];
        f1 = m_q[1]; f2 = m_q[2]; f3 = m_q[3];
`ifdef REG_CMD_CHECKSUM_EN
        if (xs != m_q[4]) begin
          e_ferr = 1; e_code = 2'b11;
        end else begin
          e_valid = 1; e_addr = m_q[0]; e_data = {f3[0], f2, f1};
        end
`else
        e_valid = 1; e_addr = m_q[0]; e_data = {f3[0], f2, f1};
`endif
        m_q.delete();
        m_drain = 1;
      end
    end else begin
      m_idle++;
      if (m_idle >= TO) begin
        e_ferr = 1; e_code = 2'b10;
        m_q.delete();
        m_drain = 1;
      end
    end
    e_busy = m_drain || (m_q.size() != 0);
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ":valid"}, 32'(bus.reg_input_valid), 32'(e_valid));
    chk({ph, ":ferr"},  32'(bus.frame_err),       32'(e_ferr));
    chk({ph, ":addr"},  32'(bus.reg_addr),        32'(e_addr));
    chk({ph, ":data"},  32'(bus.reg_data),        32'(e_data));
    chk({ph, ":code"},  32'(bus.err_code),        32'(e_code));
    chk({ph, ":busy"},  32'(bus.busy),            32'(e_busy));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare after it.
  task automatic step(input string ph, input logic cs, input logic v, input logic [7:0] b);
    bus.spi_cs_n      = cs;
    bus.rx_byte       = b;
    bus.rx_byte_valid = v;
    @(posedge clk);
    model(cs, v, b);
    #1;
    compare_all(ph);
  endtask

  task automatic send(input string ph, input logic [7:0] b);
    step(ph, 1'b0, 1'b1, b);
  endtask

  task automatic idle(input string ph, input int n, input logic cs);
    for (int i = 0; i < n; i++) step(ph, cs, 1'b0, 8'h00);
  endtask

  initial begin
    logic       cs, v;
    logic [7:0] b;
    int         vprob;
    int         pulses;

    bus.spi_cs_n      = 1'b1;
    bus.rx_byte       = 8'h00;
    bus.rx_byte_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Good frame on consecutive cycles.
`ifdef REG_CMD_CHECKSUM_EN
    send("good", 8'h07); send("good", 8'h34); send("good", 8'h12); send("good", 8'h01);
    send("good", 8'h07 ^ 8'h34 ^ 8'h12 ^ 8'h01);
`else
    send("good", 8'h07); send("good", 8'h34); send("good", 8'h12); send("good", 8'h01);
`endif
    chk("good_pulse", 32'(bus.reg_input_valid), 32'd1);
    chk("good_addr",  32'(bus.reg_addr),        32'h07);
    chk("good_data",  32'(bus.reg_data),        32'h11234);
    idle("good_end", 2, 1'b1);

    // Short frame keeps previous outputs.
    send("short", 8'h08); send("short", 8'h55);
    step("short", 1'b1, 1'b0, 8'h00);
    chk("short_err",  32'(bus.err_code), 32'd1);
    chk("short_addr", 32'(bus.reg_addr), 32'h07);
    idle("short_end", 1, 1'b1);
    chk("short_busy", 32'(bus.busy), 32'd0);

    // Timeout after 16 idle cycles, then draining until chip select rises.
    send("tmo", 8'h09);
    idle("tmo", TO, 1'b0);
    chk("tmo_err", 32'(bus.err_code), 32'd2);
    send("tmo_drain", 8'h0B); send("tmo_drain", 8'h0C);
    idle("tmo_end", 2, 1'b1);
    send("after_tmo", 8'h0A); send("after_tmo", 8'h01);
    send("after_tmo", 8'h00); send("after_tmo", 8'h00);
`ifdef REG_CMD_CHECKSUM_EN
    send("after_tmo", 8'h0B);
`endif
    chk("after_tmo_data", 32'(bus.reg_data), 32'h00001);
    idle("after_tmo_end", 2, 1'b1);

`ifdef REG_CMD_CHECKSUM_EN
    send("csum", 8'h09); send("csum", 8'hAA); send("csum", 8'h55); send("csum", 8'h00);
    send("csum", 8'hF6);
    chk("csum_data", 32'(bus.reg_data), 32'h055AA);
    idle("csum_end", 2, 1'b1);
    send("csum_bad", 8'h09); send("csum_bad", 8'hAA); send("csum_bad", 8'h55);
    send("csum_bad", 8'h00); send("csum_bad", 8'hF7);
    chk("csum_bad_err", 32'(bus.err_code), 32'd3);
    idle("csum_bad_end", 2, 1'b1);
`endif

    // Extra bytes after a complete frame: one pulse, no error.
    pulses = 0;
    send("extra", 8'h07); send("extra", 8'h01); send("extra", 8'h00); send("extra", 8'h00);
`ifdef REG_CMD_CHECKSUM_EN
    send("extra", 8'h06);
`endif
    pulses += int'(bus.reg_input_valid);
    send("extra", 8'hFF); pulses += int'(bus.reg_input_valid);
    send("extra", 8'hFF); pulses += int'(bus.reg_input_valid);
    chk("extra_pulses", 32'(pulses), 32'd1);
    idle("extra_end", 2, 1'b1);

    // Asynchronous reset in the middle of a frame.
    send("midrst", 8'h21); send("midrst", 8'h22);
    rstn = 1'b0;
    #1;
    model_reset();
    compare_all("midrst_async");
    chk("midrst_addr", 32'(bus.reg_addr), 32'h00);
    @(negedge clk);
    rstn = 1'b1;
    send("post_rst", 8'h33); send("post_rst", 8'h44); send("post_rst", 8'h55);
    send("post_rst", 8'h01);
`ifdef REG_CMD_CHECKSUM_EN
    send("post_rst", 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h01);
`endif
    chk("post_rst_data", 32'(bus.reg_data), 32'h15544);
    idle("post_rst_end", 2, 1'b1);

    // Randomized traffic with varying byte density so timeouts also occur.
    cs    = 1'b1;
    vprob = 2;
    for (int i = 0; i < 4000; i++) begin
      if (cs) begin
        if ($urandom_range(3) == 0) begin
          cs    = 1'b0;
          vprob = ($urandom_range(3) == 0) ? 20 : 2;
        end
      end else if ($urandom_range(39) == 0) begin
        cs = 1'b1;
      end
      v = ($urandom_range(vprob - 1) == 0);
      b = 8'($urandom);
      step("rand", cs, v, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
